wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (MEM/WB stage output) and out-of-band results from the multi-cycle execution unit (divider/long loads). Multi-cycle results are buffered in a small FIFO. The FIFO drains in pipeline idle slots, and the block forces a one-cycle pipeline stall when a buffered result starves. A scoreboard query exposes pending destination registers to decode for RAW/WAW interlock.

## Interface
Parameters:
- DEPTH, 2, multi-cycle result FIFO entries; power of two, ≥2
- STARVE_MAX, 4, cycles the FIFO head may be blocked before a forced drain; ≥1

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- pipe_wren_i  in  1  pipeline WB write enable
- pipe_addr_i  in  5  pipeline WB destination
- pipe_data_i  in  32  pipeline WB data
- mc_valid_i  in  1  multi-cycle result valid
- mc_addr_i  in  5  multi-cycle destination
- mc_data_i  in  32  multi-cycle data
- mc_ready_o  out  1  FIFO can accept; equals !full
- stall_o  out  1  freeze pipeline; WB inputs ignored this cycle
- q_addr_i  in  15  query {rd, rs2, rs1}, 5 bits each
- q_pend_o  out  3  per-query pending flag, same bit order
- rf_wren_o  out  1  register-file write enable (registered)
- rf_addr_o  out  5  register-file write address (registered)
- rf_data_o  out  32  register-file write data (registered)

## Operation
- Pipe write is valid when pipe_wren_i=1 and pipe_addr_i≠0. Writes to x0 count as an idle slot.
- Push: mc_valid_i && mc_ready_o. If mc_addr_i=0, the result is accepted and discarded; it is not stored.
- FSM states: NORMAL, FORCE. stall_o = (state==FORCE), a Moore output.
- In NORMAL:
  - A valid pipe write is granted.
  - Otherwise, a non-empty FIFO pops its head and writes it.
  - Otherwise, no write occurs.
- Age counter:
  - Cleared when the FIFO is empty or on pop.
  - Increments while the head is present and not popped; saturates at STARVE_MAX.
  - If age==STARVE_MAX-1 and the head is not popped this cycle, next state is FORCE.
- In FORCE:
  - Pipe inputs are ignored; the pipeline holds them.
  - The FIFO pops its head and writes it. Age is cleared. Next state is NORMAL.
  - stall_o is high for exactly one cycle.
- Push and pop may occur in the same cycle. Pushing into an empty FIFO does not bypass; the earliest write of that entry is the following cycle.
- q_pend_o[i] is combinational. It is 1 when q_addr field i≠0 and matches a valid FIFO entry or an accepted nonzero push this cycle.
- Address 0 is never pending.
- Writes occur in FIFO order. Decode uses q_pend_o to prevent RAW and WAW between pipe and FIFO results.

## Timing
- Write latency: one cycle from the grant decision to rf_* outputs.
- Reset values: rf_wren_o=0, rf_addr_o=0, rf_data_o=0, stall_o=0, mc_ready_o=1 after reset, q_pend_o=0.
- Reset state: state=NORMAL, FIFO empty, age=0.
- Reset mid-operation discards all FIFO contents and any pending FORCE.
- mc_ready_o is based only on the current occupancy. When the FIFO is full, a same-cycle pop does not allow a push.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- Worst-case head wait is STARVE_MAX+1 cycles from the head becoming head to the rf write.

## Structure
- Package wb_pkg:
  - typedef wb_req_t {addr[4:0], data[31:0]}
  - enum arb_state_t {NORMAL, FORCE}
  - constant REG_ZERO=5'd0
- Sub-module wb_fifo: parameterised DEPTH, payload wb_req_t. Exposes push, pop, full, empty, head, and a flat valid/addr vector for the scoreboard compare.
- Top level contains the FSM, age counter, grant mux, output registers, and query compare.

## Test plan
- Reset, then idle: all rf_* outputs are 0; mc_ready_o=1 and stall_o=0 after the first clock.
- mc push x5=0xDEADBEEF with pipe idle: push at cycle 0, rf_wren_o=1, rf_addr_o=5, rf_data_o=0xDEADBEEF at cycle 2. Query rs1=5 gives q_pend_o[0]=1 in cycles 0–1, then 0.
- Pipe writes x1..x8 back-to-back with one mc push x9: x9 is blocked. With STARVE_MAX=4, stall_o=1 for one cycle after 4 blocked cycles. x9 is written next; the held pipe write follows on the next cycle with no loss.
- Fill the FIFO with pushes x10 and x11: mc_ready_o=0. A third mc_valid_i is held until a pop, then accepted.
- mc push to x0 and pipe write to x0: no rf write, q_pend_o stays 0. The FIFO drains the other entry in the x0 pipe slot.
- Assert rst_i while the FIFO holds 2 entries and state=FORCE: next cycle, state=NORMAL, FIFO empty, and no rf write of the old entries.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
//   wb_req_t    : buffered write request {addr, data}
//   arb_state_t : arbiter FSM states
//   REG_ZERO    : architectural zero register, never written or pending
package wb_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned Q_PORTS = 3;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus bundle between the pipeline / multi-cycle unit and the arbiter.
//   pipe_*  : in-order pipeline writeback request
//   mc_*    : multi-cycle unit result handshake
//   stall_o : pipeline freeze
//   q_*     : decode scoreboard query {rd, rs2, rs1} and per-field pending flags
//   rf_*    : register-file write port
// slave is the arbiter's view, master is the environment's view.
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic                     pipe_wren_i;
  logic [REG_AW-1:0]        pipe_addr_i;
  logic [DATA_W-1:0]        pipe_data_i;
  logic                     mc_valid_i;
  logic [REG_AW-1:0]        mc_addr_i;
  logic [DATA_W-1:0]        mc_data_i;
  logic                     mc_ready_o;
  logic                     stall_o;
  logic [Q_PORTS*REG_AW-1:0] q_addr_i;
  logic [Q_PORTS-1:0]       q_pend_o;
  logic                     rf_wren_o;
  logic [REG_AW-1:0]        rf_addr_o;
  logic [DATA_W-1:0]        rf_data_o;

  modport slave (
    input  pipe_wren_i, pipe_addr_i, pipe_data_i,
    input  mc_valid_i, mc_addr_i, mc_data_i, q_addr_i,
    output mc_ready_o, stall_o, q_pend_o,
    output rf_wren_o, rf_addr_o, rf_data_o
  );

  modport master (
    output pipe_wren_i, pipe_addr_i, pipe_data_i,
    output mc_valid_i, mc_addr_i, mc_data_i, q_addr_i,
    input  mc_ready_o, stall_o, q_pend_o,
    input  rf_wren_o, rf_addr_o, rf_data_o
  );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Multi-cycle result FIFO with per-entry valid/addr exposed for scoreboard compare.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   push_i, din_i    : write one entry (caller guarantees !full_o)
//   pop_i            : drop head (caller guarantees !empty_o)
//   full_o, empty_o  : occupancy flags
//   head_o           : oldest entry
//   valid_o, addr_o  : flat per-slot valid bits and destination addresses
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  wb_req_t                   din_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output wb_req_t                   head_o,
  output logic [DEPTH-1:0]          valid_o,
  output logic [DEPTH*REG_AW-1:0]   addr_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Push and pop never touch the same slot: that needs count==0 and count==DEPTH at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= din_i;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_i) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push_i) - CW'(pop_i);
    end
  end

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];
  assign valid_o = vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_addr
    assign addr_o[i*REG_AW +: REG_AW] = mem[i].addr;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs buffered multi-cycle results.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : writeback bundle (slave view); rf_* registered, mc_ready_o/q_pend_o combinational,
//           stall_o decoded from the FSM state
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  wb_port_arbiter_if.slave  bus
);

  localparam int unsigned AGE_W = $clog2(STARVE_MAX + 1);

  arb_state_t               state;
  logic [AGE_W-1:0]         age;
  logic                     rf_wren_q;
  logic [REG_AW-1:0]        rf_addr_q;
  logic [DATA_W-1:0]        rf_data_q;

  logic                     pipe_valid;
  logic                     push;
  logic                     push_store;
  logic                     grant_pipe;
  logic                     pop;
  logic                     force_next;
  logic                     full;
  logic                     empty;
  wb_req_t                  head;
  wb_req_t                  push_req;
  logic [DEPTH-1:0]         valid_vec;
  logic [DEPTH*REG_AW-1:0]  addr_vec;
  logic [Q_PORTS-1:0]       q_pend;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_store),
    .din_i   (push_req),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .valid_o (valid_vec),
    .addr_o  (addr_vec)
  );

  // Grant decision: pipe wins in NORMAL; FIFO takes idle slots and the FORCE cycle.
  always_comb begin
    pipe_valid = bus.pipe_wren_i && (bus.pipe_addr_i != REG_ZERO);
    push       = bus.mc_valid_i && !full;
    push_store = push && (bus.mc_addr_i != REG_ZERO);
    push_req   = '{addr: bus.mc_addr_i, data: bus.mc_data_i};
    grant_pipe = (state == NORMAL) && pipe_valid;
    pop        = !empty && !grant_pipe;
    force_next = (state == NORMAL) && !empty && !pop && (age == AGE_W'(STARVE_MAX - 1));
  end

  // FSM, head age counter and registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= NORMAL;
      age       <= '0;
      rf_wren_q <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state <= force_next ? FORCE : NORMAL;

      if (empty || pop)
        age <= '0;
      else if (age != AGE_W'(STARVE_MAX))
        age <= age + AGE_W'(1);

      if (grant_pipe) begin
        rf_wren_q <= 1'b1;
        rf_addr_q <= bus.pipe_addr_i;
        rf_data_q <= bus.pipe_data_i;
      end else if (pop) begin
        rf_wren_q <= 1'b1;
        rf_addr_q <= head.addr;
        rf_data_q <= head.data;
      end else begin
        rf_wren_q <= 1'b0;
        rf_addr_q <= '0;
        rf_data_q <= '0;
      end
    end
  end

  // Scoreboard: a query field is pending if it matches a buffered entry or this cycle's stored push.
  always_comb begin
    q_pend = '0;
    for (int i = 0; i < int'(Q_PORTS); i++) begin
      logic [REG_AW-1:0] fld;
      logic              hit;
      fld = bus.q_addr_i[i*REG_AW +: REG_AW];
      hit = push_store && (bus.mc_addr_i == fld);
      for (int j = 0; j < int'(DEPTH); j++)
        hit = hit || (valid_vec[j] && (addr_vec[j*REG_AW +: REG_AW] == fld));
      q_pend[i] = hit && (fld != REG_ZERO);
    end
  end

  assign bus.mc_ready_o = !full;
  assign bus.stall_o    = (state == FORCE);
  assign bus.q_pend_o   = q_pend;
  assign bus.rf_wren_o  = rf_wren_q;
  assign bus.rf_addr_o  = rf_addr_q;
  assign bus.rf_data_o  = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter (DEPTH=2, STARVE_MAX=4).
// Each row is driven just after a rising edge and checked on the following falling edge;
// rf_* in a row therefore show the grant made in the previous row.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [14:0] qa;
    logic        e_ready;
    logic        e_stall;
    logic [2:0]  e_pend;
    logic        e_wren;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int unsigned rst_v, pw, pa, pd, mv, ma, md, qa,
                              input int unsigned er, es, ep, ew, ea, ed);
    vec_t r;
    r.rst = 1'(rst_v); r.pw = 1'(pw); r.pa = 5'(pa); r.pd = pd;
    r.mv = 1'(mv); r.ma = 5'(ma); r.md = md; r.qa = 15'(qa);
    r.e_ready = 1'(er); r.e_stall = 1'(es); r.e_pend = 3'(ep);
    r.e_wren = 1'(ew); r.e_addr = 5'(ea); r.e_data = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst             = v.rst;
    bus.pipe_wren_i = v.pw;
    bus.pipe_addr_i = v.pa;
    bus.pipe_data_i = v.pd;
    bus.mc_valid_i  = v.mv;
    bus.mc_addr_i   = v.ma;
    bus.mc_data_i   = v.md;
    bus.q_addr_i    = v.qa;
  endtask

  localparam int unsigned Q1 = (9 << 10) | 1;             // rd=9 rs2=0 rs1=1
  localparam int unsigned Q2 = (11 << 10) | (10 << 5) | 12; // rd=11 rs2=10 rs1=12
  localparam int unsigned Q3 = (13 << 5);                  // rd=0 rs2=13 rs1=0
  localparam int unsigned Q4 = (15 << 10) | (14 << 5);     // rd=15 rs2=14 rs1=0

  initial begin
    int first_stall;
    int stall_cnt;
    logic [4:0] rf_after;

    drive(mk(1, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0));
    repeat (2) @(posedge clk);

    //        rst pw pa pd          mv ma md            qa   rdy stl pend wr addr data
    // reset and idle
    tv.push_back(mk(1, 0,0,0,        0,0,0,            5,   1,0,0, 0,0,0));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            0,   1,0,0, 0,0,0));
    // single mc push to x5, drained in idle slot, written two cycles later
    tv.push_back(mk(0, 0,0,0,        1,5,32'hDEADBEEF, 5,   1,0,1, 0,0,0));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            5,   1,0,1, 0,0,0));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            5,   1,0,0, 1,5,32'hDEADBEEF));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            0,   1,0,0, 0,0,0));
    // pipe x1..x8 back to back, x9 starves then is forced; x6 held across the stall
    tv.push_back(mk(0, 1,1,'h101,    1,9,32'h99990009, Q1,  1,0,4, 0,0,0));
    tv.push_back(mk(0, 1,2,'h102,    0,0,0,            Q1,  1,0,4, 1,1,'h101));
    tv.push_back(mk(0, 1,3,'h103,    0,0,0,            Q1,  1,0,4, 1,2,'h102));
    tv.push_back(mk(0, 1,4,'h104,    0,0,0,            Q1,  1,0,4, 1,3,'h103));
    tv.push_back(mk(0, 1,5,'h105,    0,0,0,            Q1,  1,0,4, 1,4,'h104));
    tv.push_back(mk(0, 1,6,'h106,    0,0,0,            Q1,  1,1,4, 1,5,'h105));
    tv.push_back(mk(0, 1,6,'h106,    0,0,0,            Q1,  1,0,0, 1,9,32'h99990009));
    tv.push_back(mk(0, 1,7,'h107,    0,0,0,            Q1,  1,0,0, 1,6,'h106));
    tv.push_back(mk(0, 1,8,'h108,    0,0,0,            Q1,  1,0,0, 1,7,'h107));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            Q1,  1,0,0, 1,8,'h108));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            Q1,  1,0,0, 0,0,0));
    // fill FIFO with x10,x11; x12 held while full (also across the popping cycle)
    tv.push_back(mk(0, 1,20,'h20,    1,10,'hA,         Q2,  1,0,2, 0,0,0));
    tv.push_back(mk(0, 1,20,'h20,    1,11,'hB,         Q2,  1,0,6, 1,20,'h20));
    tv.push_back(mk(0, 1,20,'h20,    1,12,'hC,         Q2,  0,0,6, 1,20,'h20));
    tv.push_back(mk(0, 1,20,'h20,    1,12,'hC,         Q2,  0,0,6, 1,20,'h20));
    tv.push_back(mk(0, 0,0,0,        1,12,'hC,         Q2,  0,0,6, 1,20,'h20));
    tv.push_back(mk(0, 0,0,0,        1,12,'hC,         Q2,  1,0,5, 1,10,'hA));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            Q2,  1,0,1, 1,11,'hB));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            Q2,  1,0,0, 1,12,'hC));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            Q2,  1,0,0, 0,0,0));
    // x0 traffic: mc x0 discarded, pipe x0 is an idle slot that drains x13
    tv.push_back(mk(0, 1,21,'h21,    1,13,'hD,         Q3,  1,0,2, 0,0,0));
    tv.push_back(mk(0, 1,0,'hBAD,    1,0,'hBAD0,       Q3,  1,0,2, 1,21,'h21));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            Q3,  1,0,0, 1,13,'hD));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            Q3,  1,0,0, 0,0,0));
    // two entries buffered, reach FORCE, reset in the FORCE cycle
    tv.push_back(mk(0, 1,22,'h22,    1,14,'hE,         Q4,  1,0,2, 0,0,0));
    tv.push_back(mk(0, 1,22,'h22,    1,15,'hF,         Q4,  1,0,6, 1,22,'h22));
    tv.push_back(mk(0, 1,22,'h22,    0,0,0,            Q4,  0,0,6, 1,22,'h22));
    tv.push_back(mk(0, 1,22,'h22,    0,0,0,            Q4,  0,0,6, 1,22,'h22));
    tv.push_back(mk(0, 1,22,'h22,    0,0,0,            Q4,  0,0,6, 1,22,'h22));
    tv.push_back(mk(1, 1,22,'h22,    0,0,0,            Q4,  0,1,6, 1,22,'h22));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            Q4,  1,0,0, 0,0,0));
    tv.push_back(mk(0, 0,0,0,        0,0,0,            Q4,  1,0,0, 0,0,0));

    foreach (tv[i]) begin
      @(posedge clk);
      #1;
      drive(tv[i]);
      @(negedge clk);
      chk($sformatf("r%0d_ready", i), 32'(bus.mc_ready_o), 32'(tv[i].e_ready));
      chk($sformatf("r%0d_stall", i), 32'(bus.stall_o),    32'(tv[i].e_stall));
      chk($sformatf("r%0d_pend",  i), 32'(bus.q_pend_o),   32'(tv[i].e_pend));
      chk($sformatf("r%0d_wren",  i), 32'(bus.rf_wren_o),  32'(tv[i].e_wren));
      chk($sformatf("r%0d_addr",  i), 32'(bus.rf_addr_o),  32'(tv[i].e_addr));
      chk($sformatf("r%0d_data",  i), bus.rf_data_o,       tv[i].e_data);
    end

    // Continuous pipe traffic with one mc push: exactly one stall, five cycles after the push,
    // and the starved entry is written right after it.
    first_stall = -1;
    stall_cnt   = 0;
    rf_after    = '0;
    @(posedge clk);
    #1;
    drive(mk(0, 1,23,'h23, 1,16,'h16, 0, 0,0,0,0,0,0));
    @(negedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      bus.mc_valid_i = 1'b0;
      @(negedge clk);
      if (bus.stall_o) begin
        stall_cnt++;
        if (first_stall < 0) first_stall = c;
      end
      if (first_stall >= 0 && c == first_stall + 1) rf_after = bus.rf_addr_o;
    end
    chk("starve_first_stall", 32'(first_stall), 32'd5);
    chk("starve_stall_count", 32'(stall_cnt),   32'd1);
    chk("starve_forced_addr", 32'(rf_after),    32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
